// File: rtl/simd_lane_alu_if.sv
// simd_lane_alu_if: operand/opcode and result handshake bundle for simd_lane_alu
interface simd_lane_alu_if #(
   parameter int BITS      = 64,
   parameter int LANE_BITS = 8
);
   localparam int LANES = BITS / LANE_BITS;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [BITS-1:0]  SrcA, SrcB, ALUResult;
   logic [2:0]       ALUControl;
   logic [LANES-1:0] LaneCarry, LaneZero;
   logic [3:0]       ALUFlags;
   modport master (
      output in_valid, SrcA, SrcB, ALUControl, out_ready,
      input  in_ready, out_valid, ALUResult, LaneCarry, LaneZero, ALUFlags
   );
   modport slave (
      input  in_valid, SrcA, SrcB, ALUControl, out_ready,
      output in_ready, out_valid, ALUResult, LaneCarry, LaneZero, ALUFlags
   );
endinterface

// File: rtl/simd_lane_alu.sv
// simd_lane_alu: lane-parallel ADD/SUB/XOR/AND/XTIME plus iterative GF(2^8) multiply behind valid/ready
module simd_lane_alu #(
   parameter int BITS      = 64,
   parameter int LANE_BITS = 8
) (
   input logic            clk,
   input logic            rst_n,
   simd_lane_alu_if.slave bus
);
   localparam int LANES = BITS / LANE_BITS;
   localparam int BYTES = BITS / 8;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t               r_state;
   logic [2:0]           r_cnt;
   logic [BITS-1:0]      r_a, r_b, r_p, r_res;
   logic [LANES-1:0]     r_carry, r_zero;
   logic [3:0]           r_flags;
   logic                 w_busy, w_accept, w_gf, w_sub, w_arith, w_last, w_load;
   logic [BITS-1:0]      w_ga, w_gb, w_gp, w_na, w_nb, w_np, w_xt, w_sum, w_res, w_fin;
   logic [LANES-1:0]     w_carry, w_ovf, w_zero, w_fc, w_fo;
   logic [LANE_BITS:0]   w_s;
   logic [LANE_BITS-1:0] w_la, w_lb;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
   endfunction

   assign w_busy        = r_state == BUSY;
   assign w_gf          = bus.ALUControl == 3'b100;
   assign w_sub         = bus.ALUControl == 3'b001;
   assign w_arith       = bus.ALUControl[2:1] == 2'b00;
   assign w_last        = w_busy && r_cnt == 3'd7;
   assign bus.in_ready  = r_state == IDLE || (r_state == DONE && bus.out_ready);
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign w_load        = w_last || (w_accept && !w_gf);
   assign bus.out_valid = r_state == DONE;
   assign bus.ALUResult = r_res;
   assign bus.LaneCarry = r_carry;
   assign bus.LaneZero  = r_zero;
   assign bus.ALUFlags  = r_flags;

   // the accept edge already performs GF iteration 0, so BUSY needs only seven more
   assign w_ga = w_busy ? r_a : bus.SrcA;
   assign w_gb = w_busy ? r_b : bus.SrcB;
   assign w_gp = w_busy ? r_p : '0;

   always_comb begin
      w_na = '0;
      w_nb = '0;
      w_np = '0;
      w_xt = '0;
      for (int j = 0; j < BYTES; j++) begin
         w_np[j*8 +: 8] = w_gp[j*8 +: 8] ^ (w_gb[j*8] ? w_ga[j*8 +: 8] : 8'h00);
         w_na[j*8 +: 8] = xtime(w_ga[j*8 +: 8]);
         w_nb[j*8 +: 8] = {1'b0, w_gb[j*8+1 +: 7]};
         w_xt[j*8 +: 8] = xtime(bus.SrcA[j*8 +: 8]);
      end
   end

   always_comb begin
      w_sum   = '0;
      w_carry = '0;
      w_ovf   = '0;
      w_s     = '0;
      w_la    = '0;
      w_lb    = '0;
      for (int i = 0; i < LANES; i++) begin
         w_la = bus.SrcA[i*LANE_BITS +: LANE_BITS];
         w_lb = w_sub ? ~bus.SrcB[i*LANE_BITS +: LANE_BITS] : bus.SrcB[i*LANE_BITS +: LANE_BITS];
         w_s  = {1'b0, w_la} + {1'b0, w_lb} + {{LANE_BITS{1'b0}}, w_sub};
         w_sum[i*LANE_BITS +: LANE_BITS] = w_s[LANE_BITS-1:0];
         w_carry[i] = w_s[LANE_BITS];
         w_ovf[i]   = w_la[LANE_BITS-1] == w_lb[LANE_BITS-1] && w_s[LANE_BITS-1] != w_la[LANE_BITS-1];
      end
   end

   assign w_res = w_arith                    ? w_sum :
                  bus.ALUControl == 3'b010   ? bus.SrcA ^ bus.SrcB :
                  bus.ALUControl == 3'b011   ? bus.SrcA & bus.SrcB :
                  bus.ALUControl == 3'b101   ? w_xt : '0;
   assign w_fin = w_busy ? w_np : w_res;
   assign w_fc  = w_busy || !w_arith ? '0 : w_carry;
   assign w_fo  = w_busy || !w_arith ? '0 : w_ovf;

   always_comb begin
      w_zero = '0;
      for (int i = 0; i < LANES; i++)
         w_zero[i] = w_fin[i*LANE_BITS +: LANE_BITS] == '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_p     <= '0;
         r_res   <= '0;
         r_carry <= '0;
         r_zero  <= '1;
         r_flags <= 4'b0001;
      end else begin
         if (w_busy || w_accept) begin
            r_a <= w_na;
            r_b <= w_nb;
            r_p <= w_np;
         end
         if (w_busy) begin
            r_cnt   <= w_last ? 3'd0 : r_cnt + 3'd1;
            r_state <= w_last ? DONE : BUSY;
         end else if (w_accept) begin
            r_cnt   <= w_gf ? 3'd1 : 3'd0;
            r_state <= w_gf ? BUSY : DONE;
         end else if (r_state == DONE && bus.out_ready)
            r_state <= IDLE;
         if (w_load) begin
            r_res   <= w_fin;
            r_carry <= w_fc;
            r_zero  <= w_zero;
            r_flags <= {|w_fo, |w_fc, w_fin[BITS-1], &w_zero};
         end
      end
   end
endmodule

// File: tb/tb_simd_lane_alu.sv
// tb_simd_lane_alu: randomized and directed checks of simd_lane_alu against an arithmetic reference model
module tb_simd_lane_alu;
   localparam int LB = 8;
   localparam int LN = 8;
   logic clk = 0;
   logic rst_n = 0;
   int n_chk = 0;
   int n_fail = 0;
   logic [63:0] obs_res, er;
   logic [7:0] ec, ez;
   logic [3:0] ef;
   logic [63:0] exp_q [4];
   int lat;
   logic seen;

   simd_lane_alu_if bus ();
   simd_lane_alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] p = '0;
      for (int i = 0; i < 8; i++) if (y[i]) p ^= 15'(x) << i;
      for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11B << (i - 8);
      return p[7:0];
   endfunction

   task automatic model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        output logic [63:0] r, output logic [7:0] c, output logic [7:0] z, output logic [3:0] f);
      logic ov = 0;
      int half = 1 << (LB - 1);
      int full = 1 << LB;
      r = '0;
      c = '0;
      z = '0;
      for (int i = 0; i < LN; i++) begin
         int x = int'(a[i*LB +: LB]);
         int y = int'(b[i*LB +: LB]);
         int sx = x >= half ? x - full : x;
         int sy = y >= half ? y - full : y;
         if (op == 3'd0) begin
            r[i*LB +: LB] = LB'(x + y);
            c[i] = x + y >= full;
            ov |= (sx + sy >= half) || (sx + sy < -half);
         end else if (op == 3'd1) begin
            r[i*LB +: LB] = LB'(x - y);
            c[i] = x >= y;
            ov |= (sx - sy >= half) || (sx - sy < -half);
         end
      end
      if (op == 3'd2) r = a ^ b;
      if (op == 3'd3) r = a & b;
      if (op == 3'd4 || op == 3'd5)
         for (int j = 0; j < 8; j++) r[j*8 +: 8] = gmul(a[j*8 +: 8], op == 3'd5 ? 8'h02 : b[j*8 +: 8]);
      for (int i = 0; i < LN; i++) z[i] = r[i*LB +: LB] == '0;
      f = {ov, |c, r[63], &z};
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
      logic [63:0] r;
      logic [7:0] c, z;
      logic [3:0] f;
      int l;
      model(a, b, op, r, c, z, f);
      @(negedge clk);
      bus.SrcA = a;
      bus.SrcB = b;
      bus.ALUControl = op;
      bus.in_valid = 1;
      bus.out_ready = 1;
      check("in_ready", 64'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 0;
      l = 1;
      while (!bus.out_valid && l < 20) begin
         bus.SrcA = {$urandom, $urandom};
         bus.SrcB = {$urandom, $urandom};
         bus.ALUControl = 3'($urandom);
         @(negedge clk);
         l++;
      end
      check("latency", 64'(l), op == 3'd4 ? 64'd8 : 64'd1);
      check("result", bus.ALUResult, r);
      check("carry", 64'(bus.LaneCarry), 64'(c));
      check("zero", 64'(bus.LaneZero), 64'(z));
      check("flags", 64'(bus.ALUFlags), 64'(f));
      obs_res = bus.ALUResult;
   endtask

   initial begin
      bus.in_valid = 0;
      bus.out_ready = 0;
      bus.SrcA = '0;
      bus.SrcB = '0;
      bus.ALUControl = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(bus.out_valid), 0);
      check("rst_res", bus.ALUResult, 0);
      check("rst_carry", 64'(bus.LaneCarry), 0);
      check("rst_zero", 64'(bus.LaneZero), 64'hFF);
      check("rst_flags", 64'(bus.ALUFlags), 64'b0001);
      rst_n = 1;
      #1 check("rdy_after_rst", 64'(bus.in_ready), 1);

      run_op(64'h7FFF, 64'h0101, 3'd0);
      check("add_dir_res", obs_res, 64'h8000);
      check("add_dir_carry", 64'(bus.LaneCarry), 64'h01);
      check("add_dir_flags", 64'(bus.ALUFlags), 64'b1100);
      run_op({8{8'h57}}, {8{8'h83}}, 3'd4);
      check("gf_c1", obs_res, {8{8'hC1}});
      run_op({8{8'h57}}, {8{8'h13}}, 3'd4);
      check("gf_fe", obs_res, {8{8'hFE}});
      run_op({8{8'h80}}, 64'h1234, 3'd5);
      check("xt_1b", obs_res, {8{8'h1B}});
      run_op({8{8'h57}}, 64'hFFFF, 3'd5);
      check("xt_ae", obs_res, {8{8'hAE}});
      run_op(64'hDEAD_BEEF_0123_4567, 64'h1, 3'd6);
      check("rsv_res", obs_res, 0);
      run_op(64'h8000_0000_0000_0000, 64'h0100_0000_0000_0000, 3'd1);

      for (int k = 0; k < 40; k++) begin
         logic [63:0] a, b;
         a = {$urandom, $urandom};
         b = $urandom_range(0, 3) == 0 ? a : {$urandom, $urandom};
         run_op(a, b, 3'($urandom_range(0, 7)));
      end

      // backpressure on a GF multiply with garbage inputs throughout
      model(64'h0102_0408_1020_4080, {8{8'hA5}}, 3'd4, er, ec, ez, ef);
      @(negedge clk);
      bus.SrcA = 64'h0102_0408_1020_4080;
      bus.SrcB = {8{8'hA5}};
      bus.ALUControl = 3'd4;
      bus.in_valid = 1;
      bus.out_ready = 0;
      @(negedge clk);
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         check("busy_rdy", 64'(bus.in_ready), 0);
         bus.SrcA = {$urandom, $urandom};
         bus.ALUControl = 3'($urandom);
         @(negedge clk);
         lat++;
      end
      check("bp_latency", 64'(lat), 8);
      repeat (5) begin
         check("bp_valid", 64'(bus.out_valid), 1);
         check("bp_rdy", 64'(bus.in_ready), 0);
         check("bp_res", bus.ALUResult, er);
         check("bp_flags", 64'(bus.ALUFlags), 64'(ef));
         bus.SrcA = {$urandom, $urandom};
         @(negedge clk);
      end
      bus.in_valid = 0;
      bus.out_ready = 1;
      @(negedge clk);
      check("bp_drain", 64'(bus.out_valid), 0);

      // back-to-back XORs
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            check("b2b_valid", 64'(bus.out_valid), 1);
            check("b2b_res", bus.ALUResult, exp_q[k-1]);
         end
         if (k < 4) begin
            bus.SrcA = {$urandom, $urandom};
            bus.SrcB = {$urandom, $urandom};
            bus.ALUControl = 3'd2;
            bus.in_valid = 1;
            exp_q[k] = bus.SrcA ^ bus.SrcB;
            check("b2b_rdy", 64'(bus.in_ready), 1);
         end else
            bus.in_valid = 0;
         @(negedge clk);
      end
      check("b2b_end", 64'(bus.out_valid), 0);

      // reset in the middle of a GF multiply
      bus.SrcA = {8{8'h57}};
      bus.SrcB = {8{8'h83}};
      bus.ALUControl = 3'd4;
      bus.in_valid = 1;
      @(posedge clk);
      #1 bus.in_valid = 0;
      repeat (4) @(posedge clk);
      #2 rst_n = 0;
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 0);
      check("mid_rst_flags", 64'(bus.ALUFlags), 64'b0001);
      check("mid_rst_res", bus.ALUResult, 0);
      @(negedge clk);
      rst_n = 1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1;
      end
      check("no_pulse", 64'(seen), 0);
      run_op(64'h01, 64'h01, 3'd0);
      check("post_rst_add", obs_res, 64'h02);

      // reset while holding a result in DONE
      @(negedge clk);
      bus.SrcA = 64'hFF;
      bus.SrcB = 64'h0F;
      bus.ALUControl = 3'd2;
      bus.in_valid = 1;
      bus.out_ready = 0;
      @(negedge clk);
      bus.in_valid = 0;
      check("done_valid", 64'(bus.out_valid), 1);
      rst_n = 0;
      #1 check("done_rst_valid", 64'(bus.out_valid), 0);
      check("done_rst_zero", 64'(bus.LaneZero), 64'hFF);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      check("done_rst_idle", 64'(bus.out_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/simd_lane_alu.md
SIMD_LANE_ALU -- requirements
Module: simd_lane_alu

Interface
REQ-001 Parameter BITS, default 64; total datapath width; SHALL be a multiple of LANE_BITS.
REQ-002 Parameter LANE_BITS, default 8; lane width; SHALL be a multiple of 8.
REQ-003 Derived LANES = BITS/LANE_BITS, default 8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand/opcode presented.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 SrcA, SrcB  input  BITS  operands; lane i = bits [i*LANE_BITS +: LANE_BITS].
REQ-009 ALUControl  input  3  opcode: 000 ADD, 001 SUB, 010 XOR, 011 AND, 100 GFMUL, 101 XTIME; 110/111 reserved.
REQ-010 out_valid  output  1  ALUResult/flags valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 ALUResult  output  BITS  registered result.
REQ-013 LaneCarry  output  LANES  per-lane carry-out (ADD) / no-borrow (SUB); 0 for other ops.
REQ-014 LaneZero  output  LANES  per-lane result == 0.
REQ-015 ALUFlags  output  4  {Overflow, Carry, Neg, Zero}: OR of lane signed overflows, OR of LaneCarry, ALUResult[BITS-1], AND of LaneZero.

Function
REQ-016 ADD/SUB: lane-independent, modulo 2^LANE_BITS, no carry propagation across lanes; SUB = A + ~B + 1 per lane.
REQ-017 Lane overflow: ADD when A,B signs equal and result sign differs; SUB when A,B signs differ and result sign differs from A.
REQ-018 XOR/AND: bitwise over full BITS.
REQ-019 GFMUL: each 8-bit byte of A times the matching byte of B in GF(2^8), polynomial 0x11B, independent of LANE_BITS.
REQ-020 XTIME: each byte of A times 0x02 in GF(2^8); SrcB ignored.
REQ-021 Reserved opcodes: accepted, result 0, LaneCarry 0, flags computed from the zero result.
REQ-022 FSM states IDLE, BUSY, DONE; in_ready = (IDLE) or (DONE and out_ready).
REQ-023 Accept = in_valid and in_ready; operands and opcode latched on accept.
REQ-024 Single-cycle ops (ADD, SUB, XOR, AND, XTIME, reserved): accept in cycle N -> DONE with out_valid=1 at N+1.
REQ-025 GFMUL: iterative shift-and-add, one B bit per cycle for all bytes in parallel, 8 iterations in BUSY; accept at N -> out_valid=1 at N+8.
REQ-026 GFMUL iteration counter 3 bits; it SHALL NOT wrap while BUSY; BUSY -> DONE after the 8th iteration.
REQ-027 DONE holds ALUResult, LaneCarry, LaneZero and ALUFlags stable until out_ready=1.
REQ-028 DONE and out_ready with no accept -> IDLE, out_valid=0 next cycle.
REQ-029 DONE and out_ready with accept the same cycle -> new operation starts with no bubble; back-to-back single-cycle ops sustain one result per cycle.
REQ-030 in_valid while BUSY, or in DONE without out_ready: ignored (in_ready=0); SrcA/SrcB/ALUControl changes do not affect the operation in flight.
REQ-031 Outputs change only on the transition into DONE, never while out_valid=1 and out_ready=0.

Reset
REQ-032 rst_n=0 forces IDLE asynchronously; out_valid=0, ALUResult=0, LaneCarry=0, LaneZero all 1s, ALUFlags=4'b0001, counter=0.
REQ-033 Reset mid-GFMUL or mid-DONE discards the operation; no out_valid pulse follows reset release.
REQ-034 in_ready=1 in the first cycle after rst_n deasserts.

Verification
REQ-035 ADD, A=0x..._7F_FF, B=0x..._01_01, others 0 -> lane0=0x00, lane1=0x80; LaneCarry[0]=1; Overflow=1 (lane1); LaneZero[0]=1; out_valid at N+1.
REQ-036 GFMUL, A bytes all 0x57, B bytes all 0x83 -> every byte 0xC1, out_valid exactly at N+8; then B=0x13 -> every byte 0xFE.
REQ-037 XTIME, A bytes 0x80 -> 0x1B; A bytes 0x57 -> 0xAE.
REQ-038 Backpressure: out_ready=0 for 5 cycles in DONE, SrcA toggling with in_valid=1 -> result stable, in_ready=0, no second accept.
REQ-039 Back-to-back: 4 XOR ops, out_ready=1, in_valid=1 -> 4 results on 4 consecutive cycles, correct order.
REQ-040 rst_n pulsed low at GFMUL iteration 4 -> immediate IDLE, out_valid=0, ALUFlags=4'b0001; next ADD 0x01+0x01 -> lane0=0x02 at N+1.
